decoder_ctrl: RTL and testbench



---
 rtl/decoder_ctrl_if.sv | 30 +++
 rtl/decoder_ctrl.sv | 149 ++++++++++++++
 tb/tb_decoder_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/decoder_ctrl_if.sv
// Loader-side and engine-side signals of the decoder controller, plus its status outputs.
// The slave modport is the controller's view; master is the environment's view.
interface decoder_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int STACK_DEPTH = 16,
    parameter int NUM_UNITS   = 2,
    localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
);
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic [NUM_UNITS-1:0]  calc_start;
    logic [DATA_WIDTH-1:0] calc_data;
    logic [NUM_UNITS-1:0]  calc_done;
    logic [NUM_UNITS-1:0]  busy;
    logic [CNT_W-1:0]      level;
    logic [CNT_W-1:0]      proc_count;
    logic                  overflow;
    logic                  done;

    modport slave (
        input  load_valid, load_data, calc_done,
        output load_ready, calc_start, calc_data, busy, level, proc_count, overflow, done
    );

    modport master (
        output load_valid, load_data, calc_done,
        input  load_ready, calc_start, calc_data, busy, level, proc_count, overflow, done
    );
endinterface

// File: rtl/decoder_ctrl.sv
// Decoder controller: loads symbols into a LIFO stack, then pops them one per cycle
// to the lowest-numbered idle calc engine and pulses done once everything has drained.
module decoder_ctrl_lane (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic done,
    output logic busy,
    output logic accept
);
    logic busy_q, busy_d;

    // A completion is only honoured while this engine is marked busy.
    assign accept = done & busy_q;
    assign busy   = busy_q;

    always_comb begin
        busy_d = (busy_q & ~accept) | start;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= busy_d;
    end
endmodule

module decoder_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int STACK_DEPTH = 16,
    parameter int NUM_UNITS   = 2,
    localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    decoder_ctrl_if.slave bus
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DISPATCH, S_DRAIN, S_FINISH} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      level_q, level_d;
    logic [CNT_W-1:0]      proc_q, proc_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [STACK_DEPTH];

    logic [NUM_UNITS-1:0]  busy, accept, start;
    logic [CNT_W-1:0]      acc_cnt;
    logic                  full, found;
    logic [AW-1:0]         wr_idx, rd_idx;

    assign full   = (level_q == CNT_W'(STACK_DEPTH));
    assign wr_idx = AW'(level_q);
    assign rd_idx = AW'(level_q - CNT_W'(1));

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
        decoder_ctrl_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .start  (start[i]),
            .done   (bus.calc_done[i]),
            .busy   (busy[i]),
            .accept (accept[i])
        );
    end

    // Lowest-index idle engine wins; busy is the registered flag, so an engine
    // finishing this cycle is not reusable until the next one.
    always_comb begin
        start = '0;
        found = 1'b0;
        if (state_q == S_DISPATCH && level_q != '0) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (!busy[i] && !found) begin
                    start[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_cnt = '0;
        for (int i = 0; i < NUM_UNITS; i++) acc_cnt = acc_cnt + CNT_W'(accept[i]);
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        proc_d  = proc_q + acc_cnt;
        ovf_d   = ovf_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load_valid) begin
                    mem_d[wr_idx] = bus.load_data;
                    level_d       = level_q + CNT_W'(1);
                    proc_d        = '0;
                    ovf_d         = 1'b0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!bus.load_valid) begin
                    state_d = S_DISPATCH;
                end else if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_d[wr_idx] = bus.load_data;
                    level_d       = level_q + CNT_W'(1);
                end
            end
            S_DISPATCH: begin
                if (level_q == '0)  state_d = S_DRAIN;
                else if (found)     level_d = level_q - CNT_W'(1);
            end
            S_DRAIN: begin
                if (busy == '0) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            level_q <= '0;
            proc_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            proc_q  <= proc_d;
            ovf_q   <= ovf_d;
        end
        mem_q <= mem_d;
    end

    assign bus.load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign bus.calc_start = start;
    assign bus.calc_data  = mem_q[rd_idx];
    assign bus.busy       = busy;
    assign bus.level      = level_q;
    assign bus.proc_count = proc_q;
    assign bus.overflow   = ovf_q;
    assign bus.done       = (state_q == S_FINISH);
endmodule

// File: tb/tb_decoder_ctrl.sv
// Directed bench: a two-engine instance for LIFO/overflow/completion/reset cases and
// a single-engine instance for back-to-back jobs; all expected values hand-derived.
module tb_decoder_ctrl;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int done_a = 0, done_b = 0, clash = 0;

    always #5 clk = ~clk;

    decoder_ctrl_if #(.DATA_WIDTH(8), .STACK_DEPTH(4), .NUM_UNITS(2)) ia ();
    decoder_ctrl_if #(.DATA_WIDTH(8), .STACK_DEPTH(4), .NUM_UNITS(1)) ib ();

    decoder_ctrl #(.DATA_WIDTH(8), .STACK_DEPTH(4), .NUM_UNITS(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave));
    decoder_ctrl #(.DATA_WIDTH(8), .STACK_DEPTH(4), .NUM_UNITS(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave));

    always @(posedge clk) begin
        if (ia.done) done_a <= done_a + 1;
        if (ib.done) done_b <= done_b + 1;
        if ((ia.done && ia.calc_start != '0) || (ib.done && ib.calc_start != '0)) clash <= clash + 1;
    end

    task automatic go;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ia.load_valid = 0; ia.load_data = '0; ia.calc_done = '0;
        ib.load_valid = 0; ib.load_data = '0; ib.calc_done = '0;
        go; go;
        rst = 1'b0;
        #1;
        chk("rst_level", 32'(ia.level), 0);
        chk("rst_busy", 32'(ia.busy), 0);
        chk("rst_proc", 32'(ia.proc_count), 0);
        chk("rst_ovf", 32'(ia.overflow), 0);
        chk("rst_done", 32'(ia.done), 0);
        chk("rst_start", 32'(ia.calc_start), 0);
        chk("rst_ready", 32'(ia.load_ready), 1);
        go;

        // Basic LIFO dispatch, engine latency 3
        ia.load_valid = 1; ia.load_data = 8'h11; #1 chk("t1_ready", 32'(ia.load_ready), 1); go;
        ia.load_data = 8'h22; #1 chk("t1_lvl1", 32'(ia.level), 1); go;
        ia.load_data = 8'h33; go;
        ia.load_valid = 0; #1 chk("t1_lvl3", 32'(ia.level), 3); go;
        #1 chk("t1_s4", 32'(ia.calc_start), 1); chk("t1_d4", 32'(ia.calc_data), 32'h33);
        chk("t1_rdy4", 32'(ia.load_ready), 0); go;
        #1 chk("t1_s5", 32'(ia.calc_start), 2); chk("t1_d5", 32'(ia.calc_data), 32'h22); go;
        #1 chk("t1_s6", 32'(ia.calc_start), 0); chk("t1_b6", 32'(ia.busy), 3); go;
        ia.calc_done = 2'b01; #1 chk("t1_s7", 32'(ia.calc_start), 0); go;
        ia.calc_done = 2'b10; #1 chk("t1_s8", 32'(ia.calc_start), 1); chk("t1_d8", 32'(ia.calc_data), 32'h11);
        chk("t1_b8", 32'(ia.busy), 2); chk("t1_p8", 32'(ia.proc_count), 1); go;
        ia.calc_done = 0; #1 chk("t1_s9", 32'(ia.calc_start), 0); chk("t1_b9", 32'(ia.busy), 1);
        chk("t1_p9", 32'(ia.proc_count), 2); chk("t1_l9", 32'(ia.level), 0); go;
        go;
        ia.calc_done = 2'b01; #1 chk("t1_dn11", 32'(ia.done), 0); go;
        ia.calc_done = 0; #1 chk("t1_b12", 32'(ia.busy), 0); chk("t1_p12", 32'(ia.proc_count), 3);
        chk("t1_dn12", 32'(ia.done), 0); go;
        #1 chk("t1_dn13", 32'(ia.done), 1); chk("t1_p13", 32'(ia.proc_count), 3); go;
        #1 chk("t1_dn14", 32'(ia.done), 0); chk("t1_rdy14", 32'(ia.load_ready), 1);
        chk("t1_dcnt", 32'(done_a), 1); go;

        // Spurious done while idle
        ia.calc_done = 2'b10; #1; go;
        ia.calc_done = 0; #1 chk("sp_busy", 32'(ia.busy), 0); chk("sp_proc", 32'(ia.proc_count), 3);
        chk("sp_ready", 32'(ia.load_ready), 1); chk("sp_lvl", 32'(ia.level), 0); go;

        // Overflow, simultaneous completion, spurious done in DISPATCH
        for (int i = 0; i < 6; i++) begin
            ia.load_valid = 1; ia.load_data = 8'hA1 + 8'(i); #1;
            if (i == 1) begin chk("ov_pclr", 32'(ia.proc_count), 0); chk("ov_o1", 32'(ia.overflow), 0); end
            if (i == 4) begin chk("ov_l4", 32'(ia.level), 4); chk("ov_o4", 32'(ia.overflow), 0); end
            go;
        end
        ia.load_valid = 0; #1 chk("ov_lvl", 32'(ia.level), 4); chk("ov_flag", 32'(ia.overflow), 1); go;
        #1 chk("ov_s7", 32'(ia.calc_start), 1); chk("ov_d7", 32'(ia.calc_data), 32'hA4); go;
        #1 chk("ov_s8", 32'(ia.calc_start), 2); chk("ov_d8", 32'(ia.calc_data), 32'hA3); go;
        ia.calc_done = 2'b11; #1 chk("sim_s9", 32'(ia.calc_start), 0); go;
        ia.calc_done = 2'b10; #1 chk("sim_b10", 32'(ia.busy), 0); chk("sim_p10", 32'(ia.proc_count), 2);
        chk("sim_s10", 32'(ia.calc_start), 1); chk("sim_d10", 32'(ia.calc_data), 32'hA2); go;
        ia.calc_done = 0; #1 chk("spd_b11", 32'(ia.busy), 1); chk("spd_p11", 32'(ia.proc_count), 2);
        chk("spd_s11", 32'(ia.calc_start), 2); chk("spd_d11", 32'(ia.calc_data), 32'hA1); go;
        ia.calc_done = 2'b11; #1 chk("ov_s12", 32'(ia.calc_start), 0); chk("ov_l12", 32'(ia.level), 0); go;
        ia.calc_done = 0; #1 chk("ov_b13", 32'(ia.busy), 0); chk("ov_p13", 32'(ia.proc_count), 4); go;
        #1 chk("ov_dn14", 32'(ia.done), 1); chk("ov_p14", 32'(ia.proc_count), 4);
        chk("ov_o14", 32'(ia.overflow), 1); go;
        #1 chk("ov_hold", 32'(ia.overflow), 1); chk("ov_dcnt", 32'(done_a), 2); go;

        // Reset mid-job with both engines busy
        ia.load_valid = 1; ia.load_data = 8'hB1; go;
        ia.load_data = 8'hB2; #1 chk("rs_oclr", 32'(ia.overflow), 0); go;
        ia.load_data = 8'hB3; go;
        ia.load_valid = 0; go;
        #1 chk("rs_s4", 32'(ia.calc_start), 1); chk("rs_d4", 32'(ia.calc_data), 32'hB3); go;
        go;
        #1 chk("rs_b6", 32'(ia.busy), 3); rst = 1; go;
        rst = 0; ia.calc_done = 2'b11; #1
        chk("rs_lvl", 32'(ia.level), 0); chk("rs_busy", 32'(ia.busy), 0);
        chk("rs_proc", 32'(ia.proc_count), 0); chk("rs_ovf", 32'(ia.overflow), 0);
        chk("rs_start", 32'(ia.calc_start), 0); chk("rs_done", 32'(ia.done), 0);
        chk("rs_ready", 32'(ia.load_ready), 1); go;
        ia.calc_done = 0; #1 chk("rs_b8", 32'(ia.busy), 0); chk("rs_p8", 32'(ia.proc_count), 0);
        chk("rs_r8", 32'(ia.load_ready), 1); chk("rs_dcnt", 32'(done_a), 2); go;

        // Single engine, back-to-back jobs (latency 2 then 1)
        ib.load_valid = 1; ib.load_data = 8'hC1; go;
        ib.load_data = 8'hC2; #1 chk("b_l1", 32'(ib.level), 1); go;
        ib.load_valid = 0; go;
        #1 chk("b_s3", 32'(ib.calc_start), 1); chk("b_d3", 32'(ib.calc_data), 32'hC2); go;
        #1 chk("b_s4", 32'(ib.calc_start), 0); go;
        ib.calc_done = 1; #1 chk("b_s5", 32'(ib.calc_start), 0); go;
        ib.calc_done = 0; #1 chk("b_s6", 32'(ib.calc_start), 1); chk("b_d6", 32'(ib.calc_data), 32'hC1);
        chk("b_p6", 32'(ib.proc_count), 1); go;
        #1 chk("b_s7", 32'(ib.calc_start), 0); go;
        ib.calc_done = 1; go;
        ib.calc_done = 0; #1 chk("b_b9", 32'(ib.busy), 0); chk("b_p9", 32'(ib.proc_count), 2);
        chk("b_dn9", 32'(ib.done), 0); go;
        #1 chk("b_dn10", 32'(ib.done), 1); chk("b_p10", 32'(ib.proc_count), 2); go;
        ib.load_valid = 1; ib.load_data = 8'hD1; #1 chk("b_r11", 32'(ib.load_ready), 1);
        chk("b_dn11", 32'(ib.done), 0); go;
        ib.load_data = 8'hD2; #1 chk("b_p12", 32'(ib.proc_count), 0); go;
        ib.load_data = 8'hD3; go;
        ib.load_valid = 0; #1 chk("b_l14", 32'(ib.level), 3); go;
        #1 chk("b_s15", 32'(ib.calc_start), 1); chk("b_d15", 32'(ib.calc_data), 32'hD3); go;
        ib.calc_done = 1; #1 chk("b_s16", 32'(ib.calc_start), 0); go;
        ib.calc_done = 0; #1 chk("b_s17", 32'(ib.calc_start), 1); chk("b_d17", 32'(ib.calc_data), 32'hD2); go;
        ib.calc_done = 1; go;
        ib.calc_done = 0; #1 chk("b_s19", 32'(ib.calc_start), 1); chk("b_d19", 32'(ib.calc_data), 32'hD1);
        chk("b_p19", 32'(ib.proc_count), 2); go;
        ib.calc_done = 1; #1 chk("b_s20", 32'(ib.calc_start), 0); go;
        ib.calc_done = 0; #1 chk("b_p21", 32'(ib.proc_count), 3); chk("b_b21", 32'(ib.busy), 0);
        chk("b_dn21", 32'(ib.done), 0); go;
        #1 chk("b_dn22", 32'(ib.done), 1); chk("b_p22", 32'(ib.proc_count), 3); go;
        #1 chk("b_dcnt", 32'(done_b), 2); chk("clash", 32'(clash), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
